// File: rtl/alkshseq.sv
// Counted A / A:Q shift-rotate sequencer for the ALK datapath.
// Optional ALKSH_ARITH_EN: shift-in source 100 becomes a sign fill on right shifts.
module alkshseq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             start_h,
    input  logic             dir_shr_h,
    input  logic             link_q_h,
    input  logic [2:0]       sin_sel_h,
    input  logic [CNT_W-1:0] count_h,
    input  logic             pslc_flag_h,
    input  logic [WIDTH-1:0] a_in_h,
    input  logic [WIDTH-1:0] q_in_h,
    output logic [WIDTH-1:0] a_out_h,
    output logic [WIDTH-1:0] q_out_h,
    output logic             sout_h,
    output logic             busy_h,
    output logic             done_h
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_sout;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir;
    logic               r_link;
    logic [2:0]         r_sel;
    logic               r_pslc;

    logic               w_load;
    logic               w_rot;
    logic               w_sin;
    logic [WIDTH-1:0]   w_a_step;
    logic [WIDTH-1:0]   w_q_step;
    logic               w_sout_step;

    // Start is only honoured outside SHIFT; a start in DONE chains straight on.
    assign w_load = start_h && (r_state != StShift);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (start_h) begin
                    w_state_nxt = (count_h != '0) ? StShift : StDone;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StShift: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = StDone;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Rotate feeds back whichever bit is leaving the active chain.
    always_comb begin
        w_rot = r_dir ? (r_link ? r_q[0] : r_a[0]) : r_a[WIDTH-1];
        w_sin = 1'b0;
        case (r_sel)
            3'b000:  w_sin = 1'b0;
            3'b001:  w_sin = 1'b1;
            3'b010:  w_sin = w_rot;
            3'b011:  w_sin = r_pslc;
`ifdef ALKSH_ARITH_EN
            3'b100:  w_sin = r_dir ? r_a[WIDTH-1] : 1'b0;
`else
            3'b100:  w_sin = 1'b0;
`endif
            default: w_sin = 1'b0;
        endcase
    end

    always_comb begin
        w_a_step    = r_a;
        w_q_step    = r_q;
        w_sout_step = r_sout;
        if (r_dir) begin
            w_a_step = {w_sin, r_a[WIDTH-1:1]};
            if (r_link) begin
                w_q_step    = {r_a[0], r_q[WIDTH-1:1]};
                w_sout_step = r_q[0];
            end else begin
                w_sout_step = r_a[0];
            end
        end else begin
            w_sout_step = r_a[WIDTH-1];
            if (r_link) begin
                w_a_step = {r_a[WIDTH-2:0], r_q[WIDTH-1]};
                w_q_step = {r_q[WIDTH-2:0], w_sin};
            end else begin
                w_a_step = {r_a[WIDTH-2:0], w_sin};
            end
        end
    end

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_link  <= 1'b0;
            r_sel   <= 3'b000;
            r_pslc  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_a    <= a_in_h;
                r_q    <= q_in_h;
                r_sout <= 1'b0;
                r_cnt  <= count_h;
                r_dir  <= dir_shr_h;
                r_link <= link_q_h;
                r_sel  <= sin_sel_h;
                r_pslc <= pslc_flag_h;
            end else if (r_state == StShift) begin
                r_a    <= w_a_step;
                r_q    <= w_q_step;
                r_sout <= w_sout_step;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign a_out_h = r_a;
    assign q_out_h = r_q;
    assign sout_h  = r_sout;
    assign busy_h  = (r_state == StShift);
    assign done_h  = (r_state == StDone);

endmodule

// File: doc/alkshseq.md
# alkshseq

Parametrised multi-cycle A/Q shift sequencer for the ALK datapath control. It performs a counted sequence of single-bit shifts or rotates on the A register alone, or on the linked A:Q double-width chain. Each step takes its shift-in bit from a source selected at start, the same family of sources the ALU/Q shift-in routing provides. It sits alongside the ALK shift-in mux and serves long shift/normalise micro-sequences that the single-cycle mux cannot do.

## Interface
Parameters:
- WIDTH, 32, bit width of A and of Q.
- CNT_W, 6, width of the step counter; maximum count is 2^CNT_W-1.

Ports (one clock; reset is synchronous and active-high):
- clk_h  in  1  datapath clock; all state changes on the rising edge.
- reset_h  in  1  synchronous active-high reset.
- start_h  in  1  request; accepted only in IDLE or DONE.
- dir_shr_h  in  1  1 = shift right, 0 = shift left.
- link_q_h  in  1  1 = A:Q chain (A is the high half), 0 = A only, Q held.
- sin_sel_h  in  3  shift-in source:
  - 000 = 0
  - 001 = 1
  - 010 = rotate (bit leaving the chain)
  - 011 = PSL.C
  - 100 = sign (see Configuration)
  - others = 0
- count_h  in  CNT_W  number of steps.
- pslc_flag_h  in  1  PSL.C; sampled only at start.
- a_in_h  in  WIDTH  initial A.
- q_in_h  in  WIDTH  initial Q.
- a_out_h  out  WIDTH  A register.
- q_out_h  out  WIDTH  Q register.
- sout_h  out  1  last bit shifted out of the chain.
- busy_h  out  1  high while in SHIFT.
- done_h  out  1  high for exactly the one DONE cycle.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE/DONE + start_h:
  - Load A, Q, remaining count, dir, link, sel; latch pslc_flag_h; clear sout_h.
  - Next state is SHIFT if count_h≠0, else DONE.
- DONE without start → IDLE.
- start_h in SHIFT is ignored; no queueing.
- SHIFT, each edge: perform one step and decrement the remaining count. On the edge where the remaining count is 1, go to DONE.
- Step, left, linked: A ← {A[W-2:0], Q[W-1]}; Q ← {Q[W-2:0], sin}; sout ← A[W-1]; rotate sin = A[W-1].
- Step, right, linked: A ← {sin, A[W-1:1]}; Q ← {A[0], Q[W-1:1]}; sout ← Q[0]; rotate sin = Q[0].
- Step, left, A-only: A ← {A[W-2:0], sin}; sout ← A[W-1]; rotate sin = A[W-1].
- Step, right, A-only: A ← {sin, A[W-1:1]}; sout ← A[0]; rotate sin = A[0].
- PSL.C source uses the value latched at start, not the live input.
- Outputs hold their values in DONE and IDLE until the next accepted start.

## Timing
- Reset (synchronous, priority over start):
  - state=IDLE.
  - a_out_h=0, q_out_h=0, sout_h=0, busy_h=0, done_h=0, internal counter 0.
  - Reset during SHIFT aborts the operation; registers zero on that edge.
- Start sampled on edge 0; the load happens on that edge.
- For count N≥1:
  - busy_h is high in the cycles after edges 0..N-1.
  - done_h is high in the cycle after edge N.
  - Result is visible when done_h is high.
  - Total latency is N+1 cycles.
- N=0: done_h is high in the cycle after edge 0; busy_h never rises; A and Q equal the loaded values.
- Back-to-back: start asserted during DONE is accepted on that edge. done_h drops and the new operation begins; there is no IDLE bubble.
- Counter is unsigned, CNT_W wide, with no wrap. It only decrements from ≥1.

## Configuration
- ALKSH_ARITH_EN defined:
  - sin_sel 100 with a right shift takes sin = current A[W-1], giving an arithmetic right shift.
  - sin_sel 100 with a left shift takes sin = 0.
- ALKSH_ARITH_EN undefined: sin_sel 100 behaves exactly as 000 (fill 0).

## Test plan
- Rotate left, A-only: A=0x80000001, count=4, sel=010 → A=0x00000018, sout_h=0, done_h in cycle 5, busy_h high for 4 cycles.
- Linked right, fill 1: A=0x00000001, Q=0x00000000, count=1, sel=001 → A=0x80000000, Q=0x80000000, sout_h=0.
- Count 0: A=0x00001234, count=0 → done_h in the cycle after start, busy_h never high, A=0x00001234.
- Sign fill: A=0x80000000, right, A-only, count=4, sel=100 → A=0xF8000000 with ALKSH_ARITH_EN, 0x08000000 without it.
- PSL.C latch: pslc=1 at start then 0, A=0, left, count=3, sel=011 → A=0x00000007.
- Reset and ignored start:
  - start count=10; start_h pulsed again during SHIFT → ignored, done_h arrives exactly 11 cycles after the first start.
  - Repeat, and assert reset_h in the 3rd SHIFT cycle → all outputs 0, done_h never pulses.
